// File: rtl/qspi_rx_deserializer.sv
// rtl/qspi_rx_deserializer.sv - QSPI receive deserializer packing 1/2/4-lane samples into words behind a valid/ready holding register
module qspi_rx_deserializer #(
    parameter int DATA_W = 32,
    parameter int BCNT_W = $clog2(DATA_W/8)+1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic [1:0]               lane_mode,
    input  logic                     flush,
    input  logic [3:0]               qspi_io,
    output logic [DATA_W-1:0]        rx_data,
    output logic [BCNT_W-1:0]        rx_bytes,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     overflow,
    output logic [$clog2(DATA_W):0]  bit_cnt
);

    localparam int CNT_W = $clog2(DATA_W)+1;

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sr_eff;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_eff;
    logic              do_sample;
    logic              word_done;
    logic              flush_emit;
    logic              restart;
    logic              cand_valid;
    logic [DATA_W-1:0] cand_data;
    logic [BCNT_W-1:0] cand_bytes;
    logic              can_load;

    always_comb begin
        n       = '0;
        shifted = sr;
        case (lane_mode)
            2'b00: begin
                n       = CNT_W'(1);
                shifted = {sr[DATA_W-2:0], qspi_io[1]};
            end
            2'b01: begin
                n       = CNT_W'(2);
                shifted = {sr[DATA_W-3:0], qspi_io[1:0]};
            end
            2'b10: begin
                n       = CNT_W'(4);
                shifted = {sr[DATA_W-5:0], qspi_io[3:0]};
            end
            default: begin
                n       = '0;
                shifted = sr;
            end
        endcase
    end

    // The shift register is zeroed on every restart, so bits above the count
    // are always zero and a flushed word only needs the residual bits shifted out.
    always_comb begin
        do_sample  = sample_en && (lane_mode != 2'b11);
        cnt_sum    = bit_cnt + n;
        sr_eff     = do_sample ? shifted : sr;
        cnt_eff    = do_sample ? cnt_sum : bit_cnt;
        word_done  = do_sample && (cnt_sum >= CNT_W'(DATA_W));
        flush_emit = flush && !word_done && (cnt_eff >= CNT_W'(8));
        restart    = word_done || flush;
        cand_valid = word_done || flush_emit;
        cand_data  = word_done ? sr_eff : (sr_eff >> cnt_eff[2:0]);
        cand_bytes = word_done ? BCNT_W'(DATA_W/8) : BCNT_W'(cnt_eff >> 3);
        can_load   = !rx_valid || rx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_bytes <= '0;
            rx_valid <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            sr       <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_bytes <= '0;
            rx_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (restart) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (do_sample) begin
                sr      <= shifted;
                bit_cnt <= cnt_sum;
            end

            if (cand_valid) begin
                if (can_load) begin
                    rx_data  <= cand_data;
                    rx_bytes <= cand_bytes;
                    rx_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qspi_rx_deserializer.sv
// tb/tb_qspi_rx_deserializer.sv - table-driven and directed checks for qspi_rx_deserializer
module tb_qspi_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        sample_en = 1'b0;
    logic [1:0]  lane_mode = 2'b11;
    logic        flush = 1'b0;
    logic [3:0]  qspi_io = 4'h0;
    logic [31:0] rx_data;
    logic [2:0]  rx_bytes;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        overflow;
    logic [5:0]  bit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    qspi_rx_deserializer #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .sample_en (sample_en),
        .lane_mode (lane_mode),
        .flush     (flush),
        .qspi_io   (qspi_io),
        .rx_data   (rx_data),
        .rx_bytes  (rx_bytes),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overflow  (overflow),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic [2:0]  exp_bytes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] m, input logic [3:0] io, input logic f);
        @(negedge clk);
        sample_en = s;
        lane_mode = m;
        qspi_io   = io;
        flush     = f;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        flush     = 1'b0;
    endtask

    // Feeds the top nsamp*lanes bits of d MSB-first; single lane puts the
    // inverse bit on io0 so a wrong-lane pick is visible.
    task automatic feed(input logic [1:0] m, input logic [31:0] d, input int nsamp, input logic f_last);
        logic [31:0] w;
        logic [3:0]  io;
        w = d;
        for (int i = 0; i < nsamp; i++) begin
            case (m)
                2'b00: begin io = {2'b10, w[31], ~w[31]}; w = w << 1; end
                2'b01: begin io = {2'b11, w[31:30]};      w = w << 2; end
                default: begin io = w[31:28];             w = w << 4; end
            endcase
            drive(1'b1, m, io, f_last && (i == nsamp-1));
        end
    endtask

    initial begin
        vecs[0] = '{2'b10, 32'h12345678, 32'h12345678, 3'd4};
        vecs[1] = '{2'b00, 32'hA5C30F96, 32'hA5C30F96, 3'd4};
        vecs[2] = '{2'b01, 32'hDEADBEEF, 32'hDEADBEEF, 3'd4};
        vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4};
        vecs[4] = '{2'b00, 32'h00000001, 32'h00000001, 3'd4};

        #12;
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_data", rx_data, 32'd0);
        chk("reset_bytes", {29'd0, rx_bytes}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_cnt", {26'd0, bit_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            feed(vecs[v].mode, vecs[v].din,
                 vecs[v].mode == 2'b00 ? 32 : (vecs[v].mode == 2'b01 ? 16 : 8), 1'b0);
            chk($sformatf("tbl%0d_valid", v), {31'd0, rx_valid}, 32'd1);
            chk($sformatf("tbl%0d_data", v), rx_data, vecs[v].exp_data);
            chk($sformatf("tbl%0d_bytes", v), {29'd0, rx_bytes}, {29'd0, vecs[v].exp_bytes});
            chk($sformatf("tbl%0d_cnt", v), {26'd0, bit_cnt}, 32'd0);
            drive(1'b0, 2'b11, 4'h0, 1'b0);
            chk($sformatf("tbl%0d_drain", v), {31'd0, rx_valid}, 32'd0);
        end

        // single-lane command byte then quad data
        feed(2'b00, 32'h3B000000, 8, 1'b0);
        chk("mix_cnt8", {26'd0, bit_cnt}, 32'd8);
        feed(2'b10, 32'h12345600, 6, 1'b0);
        chk("mix_valid", {31'd0, rx_valid}, 32'd1);
        chk("mix_data", rx_data, 32'h3B123456);
        drive(1'b0, 2'b11, 4'h0, 1'b0);

        // flush of 12 bits keeps one byte
        feed(2'b00, 32'hAC700000, 12, 1'b0);
        drive(1'b0, 2'b11, 4'h0, 1'b1);
        chk("fl12_valid", {31'd0, rx_valid}, 32'd1);
        chk("fl12_data", rx_data, 32'h000000AC);
        chk("fl12_bytes", {29'd0, rx_bytes}, 32'd1);
        chk("fl12_cnt", {26'd0, bit_cnt}, 32'd0);
        drive(1'b0, 2'b11, 4'h0, 1'b0);

        feed(2'b00, 32'hF8000000, 5, 1'b0);
        drive(1'b0, 2'b11, 4'h0, 1'b1);
        chk("fl5_valid", {31'd0, rx_valid}, 32'd0);
        chk("fl5_cnt", {26'd0, bit_cnt}, 32'd0);

        // flush in the same cycle as the 16th sample
        feed(2'b00, 32'hBEEF0000, 16, 1'b1);
        chk("fl16_data", rx_data, 32'h0000BEEF);
        chk("fl16_bytes", {29'd0, rx_bytes}, 32'd2);
        drive(1'b0, 2'b11, 4'h0, 1'b0);

        // flush on the completing sample emits exactly one word
        feed(2'b10, 32'hCAFEF00D, 8, 1'b1);
        chk("flfull_data", rx_data, 32'hCAFEF00D);
        chk("flfull_bytes", {29'd0, rx_bytes}, 32'd4);
        drive(1'b0, 2'b11, 4'h0, 1'b0);
        chk("flfull_once", {31'd0, rx_valid}, 32'd0);

        // backpressure and overflow
        rx_ready = 1'b0;
        feed(2'b10, 32'h11111111, 8, 1'b0);
        feed(2'b10, 32'h22222222, 8, 1'b0);
        chk("bp_valid", {31'd0, rx_valid}, 32'd1);
        chk("bp_data", rx_data, 32'h11111111);
        chk("bp_ovf", {31'd0, overflow}, 32'd1);
        chk("bp_cnt", {26'd0, bit_cnt}, 32'd0);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain", {31'd0, rx_valid}, 32'd0);
        chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("bp_data_hold", rx_data, 32'h11111111);

        // asynchronous reset mid-word
        feed(2'b10, 32'h12300000, 3, 1'b0);
        chk("rst_pre_cnt", {26'd0, bit_cnt}, 32'd12);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("rst_data", rx_data, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_bytes", {29'd0, rx_bytes}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'b11, 4'h0, 1'b0);
        chk("rst_quiet", {31'd0, rx_valid}, 32'd0);

        // synchronous clear mid-word, with overflow and a held word
        rx_ready = 1'b0;
        feed(2'b10, 32'h44444444, 8, 1'b0);
        feed(2'b10, 32'h55555555, 8, 1'b0);
        feed(2'b10, 32'h66600000, 3, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clr_async_no", {31'd0, overflow}, 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        rx_ready = 1'b1;
        chk("clr_cnt", {26'd0, bit_cnt}, 32'd0);
        chk("clr_valid", {31'd0, rx_valid}, 32'd0);
        chk("clr_data", rx_data, 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);

        // idle lane mode is ignored between samples
        feed(2'b10, 32'h12000000, 2, 1'b0);
        drive(1'b1, 2'b11, 4'hF, 1'b0);
        chk("idle_cnt", {26'd0, bit_cnt}, 32'd8);
        feed(2'b10, 32'h34567800, 6, 1'b0);
        chk("post_clr_valid", {31'd0, rx_valid}, 32'd1);
        chk("post_clr_data", rx_data, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qspi_rx_deserializer.md
Name: qspi_rx_deserializer

Overview:
Parametrised receive-side deserializer for the QSPI controller read path. It samples the QSPI IO pins on each sampling pulse from the SCLK generator in single, dual or quad lane mode and packs the bits into DATA_W-bit words. Completed or flushed partial words are delivered to the AHB read FIFO through a valid/ready holding register, with a sticky overflow flag.

Parameters:
DATA_W, 32, output word width in bits; must be a multiple of 8 and at least 8.
BCNT_W, $clog2(DATA_W/8)+1, width of the byte-count output (derived; do not override).

Ports:
clk  input  1  system clock (HCLK)
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of all state, including the overflow flag
sample_en  input  1  single-cycle sampling pulse from the SCLK generator
lane_mode  input  2  00 single (io1), 01 dual, 10 quad, 11 idle (sampling ignored)
flush  input  1  emit the accumulated partial word at end of transfer
qspi_io  input  4  QSPI IO pins io3..io0
rx_data  output  DATA_W  holding-register word
rx_bytes  output  BCNT_W  number of valid bytes in rx_data (1..DATA_W/8)
rx_valid  output  1  holding register full
rx_ready  input  1  FIFO accepts the word
overflow  output  1  sticky flag: a word was dropped because the holding register was full
bit_cnt  output  $clog2(DATA_W)+1  bits accumulated in the current word

Behaviour:
- Reset (async, rst_n low): shift register, bit_cnt, rx_data, rx_bytes, rx_valid and overflow all 0.
- Priority per cycle: clear > sample/flush logic. clear has the same effect as reset, applied synchronously.
- Sample step (sample_en=1, lane_mode!=11):
  - n=1: shift in io1.
  - n=2: shift in {io1,io0}.
  - n=4: shift in {io3,io2,io1,io0}.
  - The shift register shifts left, with new bits entering at the LSBs. bit_cnt += n.
- Lane mode may change between samples mid-word (for example, a single-lane command followed by quad-lane data). The counter advances by the n in effect on each sample.
- Word complete: when bit_cnt+n >= DATA_W on a sample, that sample finishes the word. The shifted word becomes the candidate, with rx_bytes = DATA_W/8, and bit_cnt returns to 0.
  - If a mode change leaves bit_cnt+n > DATA_W, the excess MSBs are lost; only the low DATA_W bits are kept.
- Flush: on flush=1, any sample in the same cycle is applied first. The partial word is then emitted if the resulting count is at least 8.
  - Emitted data: the low floor(cnt/8)*8 bits, right-aligned, with the upper bits zero. The first-received byte sits at the highest valid byte. Residual bits (cnt mod 8) are discarded.
  - rx_bytes = floor(cnt/8), and bit_cnt returns to 0.
  - Flush with fewer than 8 bits accumulated only clears bit_cnt. Flush when the sample itself completes a word emits that full word once.
- Holding register load: a candidate loads at the next clock edge when rx_valid=0, or when rx_valid=1 and rx_ready=1 in the same cycle. rx_valid is then 1 from that edge.
- Latency: rx_valid rises one clk after the completing sample_en or flush cycle.
- Holding register drain: rx_valid && rx_ready with no load clears rx_valid. rx_data and rx_bytes hold their values until the next load.
- Overflow: a candidate arriving while rx_valid=1 and rx_ready=0 is dropped and overflow is set. The counter still resets, so the next word starts clean. overflow is cleared only by clear or reset.
- rx_data and rx_bytes are stable while rx_valid=1 and rx_ready=0.
- lane_mode=11 with sample_en: no state change. A flush in the same cycle is still honoured.
- Reset mid-transfer discards everything. There is no output after release until new samples arrive.

Test Plan:
- Quad, DATA_W=32, rx_ready=1: 8 samples with io = 1,2,...,8 -> rx_data=0x12345678, rx_bytes=4, rx_valid for 1 cycle, bit_cnt=0.
- Single: 32 samples of io1 encoding 0xA5C3_0F96 MSB-first -> rx_data=0xA5C30F96. Dual: 16 samples of pairs 0xDEADBEEF -> rx_data=0xDEADBEEF.
- Mode switch: 8 single-lane samples of 0x3B, then 6 quad samples of 0x1,0x2,...,0x6 -> rx_data=0x3B123456.
- Backpressure: rx_ready=0, quad words 0x11111111 then 0x22222222 -> rx_data stays 0x11111111, overflow=1. Raising rx_ready drains one word; overflow stays 1 until clear.
- Flush: 12 single-lane bits 1010_1100_0111 then flush -> rx_data=0x000000AC, rx_bytes=1, 4 residual bits dropped. Flush with 5 bits -> no rx_valid, bit_cnt=0.
- Reset/clear: assert rst_n low after 3 quad samples -> all outputs 0 immediately. Repeat with clear -> all outputs 0 after the clock edge; the next 8 quad samples produce a correct word.
